// File: rtl/motor_safety_sequencer.sv
// Motor enable sequencer: IDLE -> ARM -> RUN, with a latched tilt FAULT cleared by a held brake.
// Optional soft-start current ramp in RUN is built only when MOTOR_SOFTSTART_EN is defined.
module motor_safety_sequencer #(
    parameter int TILT_LIMIT = 512,
    parameter int ARM_CYCLES = 50000000,
    parameter int RAMP_DIV   = 50000,
    parameter int RAMP_STEP  = 16
) (
    input  logic               c50m,
    input  logic               reset,
    input  logic signed [11:0] ResolvedRoll,
    input  logic signed [11:0] ResolvedPitch,
    input  logic               BrakeApplied,
    input  logic               CadenceCheck,
    input  logic        [11:0] AssistanceRequirement,
    input  logic        [11:0] ThrottleTest,
    input  logic               MotorModeSelect,
    output logic        [11:0] MotorCurrentSetting,
    output logic               MotorEnable,
    output logic               FaultFlag,
    output logic        [1:0]  SeqState
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_RUN   = 2'd2,
        ST_FAULT = 2'd3
    } seq_state_e;

    if (ARM_CYCLES < 1 || RAMP_DIV < 1 || RAMP_STEP < 1 || TILT_LIMIT < 0) begin : g_bad_cfg
        $error("motor_safety_sequencer: invalid parameter value");
    end

    localparam int                CNT_W    = $clog2(ARM_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ARM_CYCLES - 1);
    // A 12-bit magnitude never exceeds 2048, so clamping the limit there keeps the compare exact.
    localparam logic [12:0]       TILT_LIM = 13'((TILT_LIMIT > 2048) ? 2048 : TILT_LIMIT);

    function automatic logic [12:0] tilt_mag(input logic signed [11:0] v);
        logic signed [12:0] ext;
        ext = {v[11], v};
        return v[11] ? 13'(-ext) : ext;
    endfunction

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [11:0]      setting_q, setting_d;
    logic             enable_q, enable_d;
    logic             fault_q, fault_d;

    logic             tilt_bad;
    logic             qualify;
    logic [11:0]      target;

`ifdef MOTOR_SOFTSTART_EN
    localparam int               DIV_W    = $clog2(RAMP_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RAMP_DIV - 1);
    localparam logic [12:0]      STEP     = 13'((RAMP_STEP > 4095) ? 4095 : RAMP_STEP);

    logic [DIV_W-1:0] div_q, div_d;
    logic             ramp_tick;
    logic [12:0]      ramp_sum;
`endif

    always_comb begin
        tilt_bad = (tilt_mag(ResolvedRoll) > TILT_LIM) || (tilt_mag(ResolvedPitch) > TILT_LIM);
        target   = MotorModeSelect ? AssistanceRequirement : ThrottleTest;
        qualify  = !BrakeApplied && CadenceCheck && !tilt_bad;
    end

    // NOTE: every signal assigned below gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        setting_d = setting_q;
`ifdef MOTOR_SOFTSTART_EN
        div_d     = '0;
        ramp_tick = 1'b0;
        ramp_sum  = '0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                setting_d = '0;
                cnt_d     = '0;
                if (tilt_bad)     state_d = ST_FAULT;
                else if (qualify) state_d = ST_ARM;
            end
            ST_ARM: begin
                setting_d = '0;
                if (tilt_bad) begin
                    state_d = ST_FAULT;
                    cnt_d   = '0;
                end else if (!qualify) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (tilt_bad) begin
                    state_d   = ST_FAULT;
                    setting_d = '0;
                end else if (BrakeApplied || !CadenceCheck) begin
                    state_d   = ST_IDLE;
                    setting_d = '0;
                end else begin
`ifdef MOTOR_SOFTSTART_EN
                    ramp_tick = (div_q == DIV_LAST);
                    div_d     = ramp_tick ? '0 : div_q + DIV_W'(1);
                    ramp_sum  = {1'b0, setting_q} + STEP;
                    // Decreases are immediate; increases only move on a tick and saturate at target.
                    if (setting_q > target)
                        setting_d = target;
                    else if (setting_q < target && ramp_tick)
                        setting_d = (ramp_sum >= {1'b0, target}) ? target : ramp_sum[11:0];
`else
                    setting_d = target;
`endif
                end
            end
            ST_FAULT: begin
                setting_d = '0;
                if (!tilt_bad && BrakeApplied) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        enable_d = (state_d == ST_RUN);
        fault_d  = (state_d == ST_FAULT);
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    // NOTE: reset is synchronous and clears every flop; there is no memory array to leave unreset.
    always_ff @(posedge c50m) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            setting_q <= '0;
            enable_q  <= 1'b0;
            fault_q   <= 1'b0;
`ifdef MOTOR_SOFTSTART_EN
            div_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            setting_q <= setting_d;
            enable_q  <= enable_d;
            fault_q   <= fault_d;
`ifdef MOTOR_SOFTSTART_EN
            div_q     <= div_d;
`endif
        end
    end

    assign MotorCurrentSetting = setting_q;
    assign MotorEnable         = enable_q;
    assign FaultFlag           = fault_q;
    assign SeqState            = state_q;

endmodule

// File: tb/tb_motor_safety_sequencer.sv
// Self-checking bench for motor_safety_sequencer: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the sequencing rules.
module tb_motor_safety_sequencer;

    localparam int TILT_LIMIT = 512;
    localparam int ARM_CYCLES = 4;
    localparam int RAMP_DIV   = 2;
    localparam int RAMP_STEP  = 100;
`ifdef MOTOR_SOFTSTART_EN
    localparam bit SOFT = 1'b1;
`else
    localparam bit SOFT = 1'b0;
`endif

    logic               c50m = 1'b0;
    logic               reset = 1'b1;
    logic signed [11:0] roll = '0;
    logic signed [11:0] pitch = '0;
    logic               brake = 1'b0;
    logic               cad = 1'b0;
    logic               mode = 1'b1;
    logic        [11:0] ar = '0;
    logic        [11:0] tt = '0;
    logic        [11:0] MotorCurrentSetting;
    logic               MotorEnable;
    logic               FaultFlag;
    logic        [1:0]  SeqState;

    motor_safety_sequencer #(
        .TILT_LIMIT(TILT_LIMIT),
        .ARM_CYCLES(ARM_CYCLES),
        .RAMP_DIV  (RAMP_DIV),
        .RAMP_STEP (RAMP_STEP)
    ) dut (
        .c50m                 (c50m),
        .reset                (reset),
        .ResolvedRoll         (roll),
        .ResolvedPitch        (pitch),
        .BrakeApplied         (brake),
        .CadenceCheck         (cad),
        .AssistanceRequirement(ar),
        .ThrottleTest         (tt),
        .MotorModeSelect      (mode),
        .MotorCurrentSetting  (MotorCurrentSetting),
        .MotorEnable          (MotorEnable),
        .FaultFlag            (FaultFlag),
        .SeqState             (SeqState)
    );

    always #5 c50m = ~c50m;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input int actual, input int expected);
        n_vec++;
        if (actual != expected) begin
            n_bad++;
            $display("FAIL %s: observed %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Behavioural model: 0=IDLE 1=ARM 2=RUN 3=FAULT, with plain running tallies.
    int m_state   = 0;
    int m_set     = 0;
    int m_streak  = 0;   // qualified cycles seen so far in ARM
    int m_good    = 0;   // consecutive brake-held, level cycles seen in FAULT
    int m_run_age = 0;   // cycles spent in RUN since entry

    task automatic model_step();
        int r, p, tgt;
        bit tilt, qual, tick;
        r = int'(roll);
        p = int'(pitch);
        if (r < 0) r = -r;
        if (p < 0) p = -p;
        tilt = (r > TILT_LIMIT) || (p > TILT_LIMIT);
        tgt  = mode ? int'(ar) : int'(tt);
        qual = !brake && cad && !tilt;
        if (reset) begin
            m_state = 0; m_set = 0; m_streak = 0; m_good = 0; m_run_age = 0;
            return;
        end
        case (m_state)
            0: begin
                m_set = 0;
                if (tilt) begin m_state = 3; m_good = 0; end
                else if (qual) begin m_state = 1; m_streak = 0; end
            end
            1: begin
                m_set = 0;
                if (tilt) begin m_state = 3; m_good = 0; end
                else if (!qual) m_state = 0;
                else begin
                    m_streak++;
                    if (m_streak == ARM_CYCLES) begin m_state = 2; m_run_age = 0; end
                end
            end
            2: begin
                if (tilt) begin m_state = 3; m_set = 0; m_good = 0; end
                else if (brake || !cad) begin m_state = 0; m_set = 0; end
                else begin
                    tick = (m_run_age % RAMP_DIV) == (RAMP_DIV - 1);
                    m_run_age++;
                    if (m_set > tgt) m_set = tgt;
                    else if (m_set < tgt) begin
                        if (!SOFT) m_set = tgt;
                        else if (tick) m_set = (m_set + RAMP_STEP > tgt) ? tgt : m_set + RAMP_STEP;
                    end
                end
            end
            default: begin
                m_set = 0;
                if (!tilt && brake) begin
                    m_good++;
                    if (m_good == ARM_CYCLES) m_state = 0;
                end else m_good = 0;
            end
        endcase
    endtask

    task automatic step(input string tag);
        @(posedge c50m);
        model_step();
        #1;
        check({tag, "/state"},   SeqState,            m_state);
        check({tag, "/setting"}, MotorCurrentSetting, m_set);
        check({tag, "/enable"},  MotorEnable,         int'(m_state == 2));
        check({tag, "/fault"},   FaultFlag,           int'(m_state == 3));
    endtask

    int exp_seq[5]  = '{1, 1, 1, 1, 2};
    int exp_soft[6] = '{0, 100, 100, 200, 200, 250};
    int brake_pct   = 3;
    int tilt_pct    = 0;
    int big[4]      = '{513, -513, 2047, -2048};

    function automatic logic signed [11:0] rand_tilt(input int pct);
        int v;
        if (int'($urandom_range(99)) < pct) begin
            if ($urandom_range(1) == 0) v = big[$urandom_range(3)];
            else v = int'($urandom_range(4095)) - 2048;
        end else begin
            v = int'($urandom_range(1024)) - 512;
        end
        return 12'(v);
    endfunction

    initial begin
        // Reset state
        reset = 1'b1;
        step("reset");
        check("reset_state", SeqState, 0);
        check("reset_setting", MotorCurrentSetting, 0);

        // Arming with target 250, then ramp
        reset = 1'b0; cad = 1'b1; mode = 1'b1; ar = 12'd250; tt = 12'd77;
        for (int i = 0; i < 5; i++) begin
            step("arm");
            check("arm_seq", SeqState, exp_seq[i]);
        end
        for (int i = 0; i < 6; i++) begin
            step("ramp");
            check("ramp_setting", MotorCurrentSetting, SOFT ? exp_soft[i] : 250);
        end

        // Brake in RUN
        brake = 1'b1;
        step("brake");
        check("brake_setting", MotorCurrentSetting, 0);
        check("brake_enable", MotorEnable, 0);
        check("brake_state", SeqState, 0);

        // Arm abort in the third ARM cycle
        brake = 1'b0;
        for (int i = 0; i < 3; i++) step("abort_arm");
        check("abort_pre", SeqState, 1);
        cad = 1'b0;
        step("abort");
        check("abort_state", SeqState, 0);
        check("abort_setting", MotorCurrentSetting, 0);

        // Mid-ramp target drop, throttle path
        cad = 1'b1; mode = 1'b0; tt = 12'd250;
        for (int i = 0; i < 5; i++) step("drop_arm");
        for (int i = 0; i < (SOFT ? 4 : 1); i++) step("drop_ramp");
        check("drop_pre", MotorCurrentSetting, SOFT ? 200 : 250);
        tt = 12'd50;
        step("drop");
        check("drop_setting", MotorCurrentSetting, 50);

        // Tilt has priority over brake in RUN, then brake-held clear
        roll = -12'sd600; brake = 1'b1;
        step("tilt");
        check("tilt_state", SeqState, 3);
        check("tilt_fault", FaultFlag, 1);
        check("tilt_setting", MotorCurrentSetting, 0);
        roll = '0;
        for (int i = 0; i < 4; i++) begin
            step("clear");
            check("clear_state", SeqState, (i < 3) ? 3 : 0);
        end

        // Tilt boundaries: 512 is fine, -513 faults, then reset in FAULT
        brake = 1'b0; roll = 12'sd512; pitch = -12'sd512;
        step("edge_ok");
        check("edge_ok_state", SeqState, 1);
        pitch = -12'sd513;
        step("edge_bad");
        check("edge_bad_state", SeqState, 3);
        reset = 1'b1;
        step("fault_reset");
        check("fault_reset_state", SeqState, 0);
        check("fault_reset_flag", FaultFlag, 0);
        check("fault_reset_enable", MotorEnable, 0);
        check("fault_reset_setting", MotorCurrentSetting, 0);
        reset = 1'b0; pitch = '0; roll = -12'sd2048;
        step("min_roll");
        check("min_roll_state", SeqState, 3);

        // Randomized traffic in regimes that alternate brake/tilt pressure
        for (int n = 0; n < 3000; n++) begin
            if (n % 32 == 0) begin
                brake_pct = ($urandom_range(1) == 0) ? 3 : 90;
                tilt_pct  = ($urandom_range(2) == 0) ? 4 : 0;
            end
            reset = ($urandom_range(299) == 0);
            brake = (int'($urandom_range(99)) < brake_pct);
            cad   = (int'($urandom_range(99)) < 95);
            roll  = rand_tilt(tilt_pct);
            pitch = rand_tilt(tilt_pct);
            if ($urandom_range(9) == 0) ar   = 12'($urandom);
            if ($urandom_range(9) == 0) tt   = 12'($urandom);
            if ($urandom_range(19) == 0) mode = 1'($urandom);
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
